// File: rtl/acia6551.sv
// 6551-compatible ACIA: TDR/RDR, status, command and control registers, 16x baud generator,
// async transmitter and receiver, and an interrupt flag gated by DTR.
module acia6551 #(
  parameter int unsigned ClkEnaHz = 14318180
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clk_ena_i,
  input  logic       cs_i,
  input  logic [1:0] addr_i,
  input  logic       we_i,
  input  logic       rd_i,
  input  logic [7:0] data_in_i,
  output logic [7:0] data_out_o,
  output logic       irq_o,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic       rts_n_o,
  output logic       dtr_n_o
);

  localparam int unsigned DivW = $clog2(ClkEnaHz / 800 + 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  function automatic logic [DivW-1:0] baud_div(input logic [3:0] code);
    int unsigned b;
    case (code)
      4'd1:    b = 50;
      4'd2:    b = 75;
      4'd3:    b = 110;
      4'd4:    b = 135;
      4'd5:    b = 150;
      4'd6:    b = 300;
      4'd7:    b = 600;
      4'd8:    b = 1200;
      4'd9:    b = 1800;
      4'd10:   b = 2400;
      4'd11:   b = 3600;
      4'd12:   b = 4800;
      4'd13:   b = 7200;
      4'd14:   b = 9600;
      default: b = 19200;
    endcase
    return DivW'((ClkEnaHz + 8 * b) / (16 * b));
  endfunction

  logic [7:0]      command_q, control_q, tdr_q, rdr_q;
  logic            tdre_q, rdrf_q, ovr_q, fe_q, pe_q, irqf_q;
  logic            we_prev_q, rd_prev_q;
  logic [DivW-1:0] bcnt_q;
  state_e          tx_st_q, rx_st_q;
  logic [7:0]      tx_sh_q, rx_sh_q;
  logic [3:0]      tx_bit_q, rx_bit_q, rx_tck_q;
  logic [5:0]      tx_tck_q;
  logic            txd_q, tx_par_q, rx_perr_q;
  logic            rx_s1_q, rx_s2_q, rx_s3_q;

  logic       wr_ev, rd_ev, prog_rst, rdr_rd, tick, tx_load, rx_done, rx_ovr, rx_load, irq_set;
  logic [1:0] tic;
  logic       par_en;
  logic [3:0] nbits;
  logic [7:0] word_mask;
  logic [5:0] stop_ticks;

  // Access events fire only on the first clk_ena cycle of a held strobe.
  assign wr_ev    = clk_ena_i & cs_i & we_i & ~we_prev_q;
  assign rd_ev    = clk_ena_i & cs_i & rd_i & ~rd_prev_q;
  assign prog_rst = wr_ev & (addr_i == 2'd1);
  assign rdr_rd   = rd_ev & (addr_i == 2'd0);
  assign tick     = clk_ena_i & (bcnt_q == '0);

  assign tic       = command_q[3:2];
  assign par_en    = command_q[5];
  assign nbits     = 4'd8 - {2'b00, control_q[6:5]};
  assign word_mask = 8'hFF >> control_q[6:5];

  always_comb begin
    stop_ticks = 6'd16;
    if (control_q[7]) stop_ticks = (nbits == 4'd5 && !par_en) ? 6'd24 : 6'd32;
  end

  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] mode);
    case (mode)
      2'b00:   return ~^d;
      2'b01:   return ^d;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign tx_load = tick & (tx_st_q == StIdle) & ~tdre_q & (tic != 2'b00) & ~prog_rst;
  assign rx_done = tick & (rx_st_q == StStop) & (rx_tck_q == 4'd15) & command_q[0] & ~prog_rst;
  assign rx_ovr  = rx_done & rdrf_q & ~rdr_rd;
  assign rx_load = rx_done & ~rx_ovr;
  assign irq_set = (rx_load & ~command_q[1]) | (tx_load & (tic == 2'b01)) | rx_ovr |
                   (rx_load & (~rx_s2_q | rx_perr_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      command_q <= 8'h00;
      control_q <= 8'h00;
      tdr_q     <= 8'h00;
      rdr_q     <= 8'h00;
      tdre_q    <= 1'b1;
      rdrf_q    <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      irqf_q    <= 1'b0;
      we_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      bcnt_q    <= '0;
    end else if (clk_ena_i) begin
      we_prev_q <= cs_i & we_i;
      rd_prev_q <= cs_i & rd_i;
      if (wr_ev && addr_i == 2'd3) bcnt_q <= baud_div(data_in_i[3:0]) - DivW'(1);
      else if (bcnt_q == '0)       bcnt_q <= baud_div(control_q[3:0]) - DivW'(1);
      else                         bcnt_q <= bcnt_q - DivW'(1);
      if (tx_load) tdre_q <= 1'b1;
      if (rdr_rd) begin
        rdrf_q <= 1'b0;
        ovr_q  <= 1'b0;
        fe_q   <= 1'b0;
        pe_q   <= 1'b0;
      end
      if (rd_ev && addr_i == 2'd1) irqf_q <= 1'b0;
      if (rx_ovr) ovr_q <= 1'b1;
      if (rx_load) begin
        rdr_q  <= rx_sh_q;
        rdrf_q <= 1'b1;
        fe_q   <= ~rx_s2_q;
        pe_q   <= rx_perr_q;
      end
      if (irq_set) irqf_q <= 1'b1;
      if (wr_ev) begin
        case (addr_i)
          2'd0: begin
            tdr_q  <= data_in_i;
            tdre_q <= 1'b0;
          end
          2'd1: begin
            command_q <= {command_q[7:5], 5'b00000};
            ovr_q     <= 1'b0;
          end
          2'd2:    command_q <= data_in_i;
          default: control_q <= data_in_i;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_st_q  <= StIdle;
      txd_q    <= 1'b1;
      tx_sh_q  <= 8'h00;
      tx_bit_q <= 4'd0;
      tx_tck_q <= 6'd0;
      tx_par_q <= 1'b0;
    end else if (clk_ena_i) begin
      if (prog_rst) begin
        tx_st_q <= StIdle;
        txd_q   <= 1'b1;
      end else if (tick) begin
        tx_tck_q <= tx_tck_q + 6'd1;
        unique case (tx_st_q)
          StIdle: begin
            if (tx_load) begin
              tx_sh_q  <= tdr_q & word_mask;
              tx_par_q <= par_bit(tdr_q & word_mask, command_q[7:6]);
              txd_q    <= 1'b0;
              tx_tck_q <= 6'd0;
              tx_st_q  <= StStart;
            end else begin
              txd_q <= (tic != 2'b11);  // break holds the line low
            end
          end
          StStart: if (tx_tck_q == 6'd15) begin
            tx_tck_q <= 6'd0;
            tx_bit_q <= 4'd0;
            txd_q    <= tx_sh_q[0];
            tx_st_q  <= StData;
          end
          StData: if (tx_tck_q == 6'd15) begin
            tx_tck_q <= 6'd0;
            if (tx_bit_q == nbits - 4'd1) begin
              txd_q   <= par_en ? tx_par_q : 1'b1;
              tx_st_q <= par_en ? StPar : StStop;
            end else begin
              tx_sh_q  <= tx_sh_q >> 1;
              txd_q    <= tx_sh_q[1];
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end
          StPar: if (tx_tck_q == 6'd15) begin
            tx_tck_q <= 6'd0;
            txd_q    <= 1'b1;
            tx_st_q  <= StStop;
          end
          StStop: if (tx_tck_q == stop_ticks - 6'd1) begin
            tx_tck_q <= 6'd0;
            tx_st_q  <= StIdle;
          end
          default: tx_st_q <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
      rx_st_q   <= StIdle;
      rx_sh_q   <= 8'h00;
      rx_bit_q  <= 4'd0;
      rx_tck_q  <= 4'd0;
      rx_perr_q <= 1'b0;
    end else if (clk_ena_i) begin
      rx_s1_q <= rxd_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      if (prog_rst || !command_q[0]) begin
        rx_st_q <= StIdle;
      end else begin
        unique case (rx_st_q)
          StIdle: if (rx_s3_q && !rx_s2_q) begin
            rx_st_q   <= StStart;
            rx_tck_q  <= 4'd0;
            rx_bit_q  <= 4'd0;
            rx_sh_q   <= 8'h00;
            rx_perr_q <= 1'b0;
          end
          StStart: if (tick) begin
            rx_tck_q <= rx_tck_q + 4'd1;
            if (rx_tck_q == 4'd7) begin
              rx_tck_q <= 4'd0;
              rx_st_q  <= rx_s2_q ? StIdle : StData;
            end
          end
          // From here the 4-bit tick count wraps, so each sample lands mid-bit.
          StData: if (tick) begin
            rx_tck_q <= rx_tck_q + 4'd1;
            if (rx_tck_q == 4'd15) begin
              rx_sh_q[rx_bit_q[2:0]] <= rx_s2_q;
              if (rx_bit_q == nbits - 4'd1) rx_st_q <= par_en ? StPar : StStop;
              else                          rx_bit_q <= rx_bit_q + 4'd1;
            end
          end
          StPar: if (tick) begin
            rx_tck_q <= rx_tck_q + 4'd1;
            if (rx_tck_q == 4'd15) begin
              rx_perr_q <= rx_s2_q != par_bit(rx_sh_q, command_q[7:6]);
              rx_st_q   <= StStop;
            end
          end
          StStop: if (tick) begin
            rx_tck_q <= rx_tck_q + 4'd1;
            if (rx_tck_q == 4'd15) rx_st_q <= StIdle;
          end
          default: rx_st_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    data_out_o = rdr_q;
    case (addr_i)
      2'd0:    data_out_o = rdr_q;
      2'd1:    data_out_o = {irqf_q, 2'b00, tdre_q, rdrf_q, ovr_q, fe_q, pe_q};
      2'd2:    data_out_o = command_q;
      default: data_out_o = control_q;
    endcase
  end

  assign irq_o   = irqf_q & command_q[0];
  assign txd_o   = (tic == 2'b00 && command_q[4]) ? rx_s2_q : txd_q;
  assign rts_n_o = (tic == 2'b00);
  assign dtr_n_o = ~command_q[0];

endmodule

// File: tb/tb_acia6551.sv
// Directed bench for acia6551: reset state, 9600 8N1 transmit timing, receive with IRQ,
// overrun, framing, parity, held write strobe and reset during a transmit.
module tb_acia6551;

  // 16 ticks per bit; 9600 -> div 93, 19200 -> div 47 at 14.31818 MHz clk_ena.
  localparam int Bit9600  = 16 * 93;
  localparam int Bit19200 = 16 * 47;

  logic       clk, rst_n, clk_ena, cs, we, rd, rxd;
  logic [1:0] addr;
  logic [7:0] din, dout;
  logic       irq, txd, rts_n, dtr_n;

  int n_total = 0;
  int n_bad   = 0;

  acia6551 dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clk_ena_i  (clk_ena),
    .cs_i       (cs),
    .addr_i     (addr),
    .we_i       (we),
    .rd_i       (rd),
    .data_in_i  (din),
    .data_out_o (dout),
    .irq_o      (irq),
    .rxd_i      (rxd),
    .txd_o      (txd),
    .rts_n_o    (rts_n),
    .dtr_n_o    (dtr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    repeat (hold) @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1 d = dout;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  // bits[0] is the start bit; followed by one bit period of idle.
  task automatic send_rx(input logic [11:0] bits, input int n, input int bitc);
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      repeat (bitc) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (bitc) @(negedge clk);
  endtask

  task automatic wait_tx_start(input int bound, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < bound) begin
      @(negedge clk);
      if (txd === 1'b0) ok = 1'b1;
      i++;
    end
  endtask

  function automatic logic [11:0] frame8(input logic [7:0] b, input logic stop);
    return {2'b11, stop, b, 1'b0};
  endfunction

  logic [7:0] st;
  logic [8:0] seq;
  bit         ok;
  int         w, edges, lows;
  logic       prev;

  initial begin
    rst_n = 1'b0; clk_ena = 1'b1; cs = 1'b0; we = 1'b0; rd = 1'b0;
    addr = 2'd1; din = 8'h00; rxd = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("reset_status", 32'(dout), 32'h10);
    check("reset_txd", 32'(txd), 32'h1);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_rts_n", 32'(rts_n), 32'h1);
    check("reset_dtr_n", 32'(dtr_n), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Transmit 0x55 at 9600 8N1, TIC=10.
    bus_wr(2'd3, 8'h1E, 1);
    bus_wr(2'd2, 8'h0B, 1);
    check("tx_rts_n", 32'(rts_n), 32'h0);
    check("tx_dtr_n", 32'(dtr_n), 32'h0);
    bus_wr(2'd0, 8'h55, 1);
    wait_tx_start(96, ok);
    check("tx_start_latency", 32'(ok), 32'h1);
    w = 0;
    while (txd === 1'b0 && w < 4000) begin
      w++;
      @(negedge clk);
    end
    check("tx_start_width", 32'(w), 32'(Bit9600));
    bus_rd(2'd1, st);
    check("tx_tdre_at_start", 32'(st), 32'h10);
    repeat (Bit9600 / 2 - 2) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      seq[k] = txd;
      repeat (Bit9600) @(negedge clk);
    end
    check("tx_bits_0x55", 32'(seq), 32'h155);
    check("tx_no_irq", 32'(irq), 32'h0);

    // Receive 0xA5 at 19200 8N1 with RX IRQ enabled.
    bus_wr(2'd3, 8'h10, 1);
    bus_wr(2'd2, 8'h09, 1);
    send_rx(frame8(8'hA5, 1'b1), 10, Bit19200);
    check("rx_irq_set", 32'(irq), 32'h1);
    bus_rd(2'd1, st);
    check("rx_status", 32'(st), 32'h98);  // TDRE still 1 from the earlier transmit
    check("rx_irq_cleared", 32'(irq), 32'h0);
    bus_rd(2'd0, st);
    check("rx_rdr", 32'(st), 32'hA5);
    bus_rd(2'd1, st);
    check("rx_rdrf_cleared", 32'(st), 32'h10);

    // Overrun: second byte arrives with RDRF still set.
    send_rx(frame8(8'h11, 1'b1), 10, Bit19200);
    send_rx(frame8(8'h22, 1'b1), 10, Bit19200);
    bus_rd(2'd1, st);
    check("ovr_status", 32'(st), 32'h9C);
    bus_rd(2'd0, st);
    check("ovr_rdr_kept", 32'(st), 32'h11);
    bus_rd(2'd1, st);
    check("ovr_cleared", 32'(st), 32'h10);

    // Framing: stop bit sent as 0.
    send_rx(frame8(8'h33, 1'b0), 10, Bit19200);
    bus_rd(2'd1, st);
    check("fe_status", 32'(st), 32'h9A);
    bus_rd(2'd0, st);
    check("fe_rdr", 32'(st), 32'h33);
    bus_rd(2'd1, st);
    check("fe_cleared", 32'(st), 32'h10);

    // Parity: 7E1, 0x41 has even weight so the correct parity bit is 0; send 1.
    bus_wr(2'd3, 8'h30, 1);
    bus_wr(2'd2, 8'h6B, 1);
    send_rx({2'b11, 1'b1, 1'b1, 7'h41, 1'b0}, 10, Bit19200);
    bus_rd(2'd1, st);
    check("pe_status", 32'(st), 32'h99);
    bus_rd(2'd0, st);
    check("pe_rdr", 32'(st), 32'h41);
    bus_rd(2'd1, st);
    check("pe_cleared", 32'(st), 32'h10);

    // Held write strobe: 0xFF gives exactly one falling edge (the start bit) per frame.
    bus_wr(2'd3, 8'h10, 1);
    bus_wr(2'd2, 8'h0B, 1);
    bus_wr(2'd0, 8'hFF, 5);
    edges = 0;
    prev  = txd;
    repeat (Bit19200 * 15) begin
      @(negedge clk);
      if (prev === 1'b1 && txd === 1'b0) edges++;
      prev = txd;
    end
    check("held_we_one_frame", 32'(edges), 32'h1);
    bus_rd(2'd1, st);
    check("held_we_tdre", 32'(st), 32'h10);

    // Reset in the middle of a transmitted 0x00.
    bus_wr(2'd0, 8'h00, 1);
    wait_tx_start(60, ok);
    check("rst_tx_started", 32'(ok), 32'h1);
    repeat (1100) @(negedge clk);
    check("rst_tx_mid_low", 32'(txd), 32'h0);
    rst_n = 1'b0;
    addr  = 2'd1;
    #1;
    check("rst_txd_high", 32'(txd), 32'h1);
    check("rst_status", 32'(dout), 32'h10);
    @(negedge clk);
    rst_n = 1'b1;
    lows  = 0;
    repeat (Bit19200 * 2) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("rst_txd_stays_high", 32'(lows), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
